// File: rtl/adder_pkg.sv
// adder_pkg: shared constants for the multi-cycle adder.
// FSM state encoding, default operand/chunk widths and a width helper.
package adder_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 8;

    // FSM state encoding shared by RTL and any tooling that decodes it.
    localparam int               STATE_W = 2;
    localparam logic [STATE_W-1:0] IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] RUN   = 2'd1;
    localparam logic [STATE_W-1:0] DONE  = 2'd2;

    // Bits needed to index n items; never less than one so that degenerate
    // configurations (a single chunk, a one-bit word) still get a real vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell, the building block of ripple_chunk.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/ripple_chunk.sv
// ripple_chunk: CHUNK-bit combinational ripple-carry adder built from
// full_adder cells. With ADDER_OVERFLOW_EN defined it also exposes the carry
// into its most significant bit so the caller can derive signed overflow.
module ripple_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
`ifdef ADDER_OVERFLOW_EN
    ,
    output logic             c_msb
`endif
);

    // carry[i] is the carry into bit i; carry[CHUNK] leaves the chunk.
    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign cout = carry[CHUNK];

`ifdef ADDER_OVERFLOW_EN
    assign c_msb = carry[CHUNK-1];
`endif

endmodule

// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: WIDTH-bit adder that processes CHUNK bits per clock.
// An operand pair is accepted in IDLE, added one chunk per RUN cycle
// (least significant chunk first, carry held in a register between cycles)
// and presented in DONE until the consumer takes it.
// Optional feature macro: ADDER_OVERFLOW_EN adds the 'ovf' output
// (two's-complement signed overflow of the full-width addition).
module multi_cycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = idx_width(NCHUNK);
    localparam int IDX_W  = idx_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_chunk
        $error("multi_cycle_adder: WIDTH must be a positive multiple of CHUNK");
    end

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [CNT_W-1:0]   cnt;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    logic [IDX_W-1:0]   base;
    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK-1:0]   chunk_sum;
    logic               chunk_cout;

    logic               accept;
    logic               last;

`ifdef ADDER_OVERFLOW_EN
    logic               chunk_c_msb;
    logic               ovf_q;
`endif

    assign accept = (state == IDLE) && in_valid;
    assign last   = (cnt == LAST_CHUNK);

    // Bit offset of the chunk being worked on this RUN cycle.
    assign base    = IDX_W'(int'(cnt) * CHUNK);
    assign a_chunk = a_q[base +: CHUNK];
    assign b_chunk = b_q[base +: CHUNK];

    ripple_chunk #(
        .CHUNK (CHUNK)
    ) u_ripple (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry_q),
        .sum   (chunk_sum),
        .cout  (chunk_cout)
`ifdef ADDER_OVERFLOW_EN
        ,
        .c_msb (chunk_c_msb)
`endif
    );

    // Next-state decode: accept in IDLE, finish after the last chunk, release on handshake.
    always_comb begin
        // NOTE: default assignment first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Control and result registers: state, chunk counter, running carry, sum and carry-out.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ADDER_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                cnt     <= '0;
                carry_q <= cin;
            end else if (state == RUN) begin
                sum_q[base +: CHUNK] <= chunk_sum;
                carry_q              <= chunk_cout;
                if (last) begin
                    cout_q <= chunk_cout;
`ifdef ADDER_OVERFLOW_EN
                    ovf_q  <= chunk_c_msb ^ chunk_cout;
`endif
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Operand capture on the accept edge; held untouched while RUN/DONE ignore in_valid.
    always_ff @(posedge clk) begin
        // NOTE: operand registers are deliberately not reset: they are only read in RUN, which is reached solely through a fresh capture.
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef ADDER_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule
